// File: rtl/pickup_write_queue.sv
// -----------------------------------------------------------------------------
// pickup_write_queue
//
// Purpose: queues maze-cell rewrite requests from the player movement stage
// and replays them into the shared maze BRAM write port, one write every three
// cycles at most (IDLE -> WRITE -> GAP). The write port is shared, so a request
// waits in IDLE while another writer owns it (port_busy).
//
// Ports:
//   mvmt_clk          in   movement clock, rising edge
//   reset             in   asynchronous, active-high reset
//   en                in   game-active enable (gates pushes and new issues)
//   we_player         in   write request level; a rising edge makes one push
//   bram_addr_player  in   [7:0] cell address (row*16+col)
//   bram_din_player   in   [8:0] replacement cell word
//   port_busy         in   another writer owns the BRAM write port
//   bram_we           out  registered write strobe, one cycle per commit
//   bram_addr         out  [7:0] registered write address, held between writes
//   bram_din          out  [8:0] registered write data, held between writes
//   fifo_count        out  [3:0] entries queued, 0..DEPTH
//   overflow          out  sticky: a push was dropped on a full queue
//   pickups_total     out  [7:0] committed writes, saturating at 255
//
// Parameter: DEPTH - queue entries, power of two in 2..8.
//
// Build option: define PICKUP_DEDUP_EN to drop a push whose address matches
// the last accepted push address (no overflow, no count change).
// -----------------------------------------------------------------------------
module pickup_write_queue #(
  parameter int DEPTH = 4
) (
  input  logic       mvmt_clk,
  input  logic       reset,
  input  logic       en,
  input  logic       we_player,
  input  logic [7:0] bram_addr_player,
  input  logic [8:0] bram_din_player,
  input  logic       port_busy,
  output logic       bram_we,
  output logic [7:0] bram_addr,
  output logic [8:0] bram_din,
  output logic [3:0] fifo_count,
  output logic       overflow,
  output logic [7:0] pickups_total
);

  localparam int         PTR_W    = $clog2(DEPTH);
  localparam logic [3:0] FULL_CNT = 4'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               we_prev;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [16:0]        mem [DEPTH];

  logic               push_req;
  logic               full;
  logic               pop;
  logic               dup;
  logic               push_ok;
  logic               drop;

  // One push per rising edge of the request level, only while the game runs.
  assign push_req = en & we_player & ~we_prev;
  assign full     = (fifo_count == FULL_CNT);

  // A full queue still accepts a push when the head leaves on the same edge.
  assign push_ok  = push_req & ~dup & (~full | pop);
  assign drop     = push_req & ~dup & full & ~pop;

`ifdef PICKUP_DEDUP_EN
  logic [7:0] last_addr;
  logic       last_valid;

  assign dup = last_valid & (bram_addr_player == last_addr);

  always_ff @(posedge mvmt_clk or posedge reset) begin
    if (reset) begin
      last_addr  <= 8'd0;
      last_valid <= 1'b0;
    end else if (push_ok) begin
      last_addr  <= bram_addr_player;
      last_valid <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge mvmt_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        // port_busy only matters here; WRITE and GAP always run to completion.
        if (en && (fifo_count != 4'd0) && !port_busy) begin
          state_next = WRITE;
          pop        = 1'b1;
        end
      end
      WRITE:   state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Edge-detect register follows we_player even while en=0, so a level held
  // across an enable change does not produce a late push.
  always_ff @(posedge mvmt_clk or posedge reset) begin
    if (reset) begin
      we_prev <= 1'b0;
    end else begin
      we_prev <= we_player;
    end
  end

  always_ff @(posedge mvmt_clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= 4'd0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 4'd1;
        2'b01:   fifo_count <= fifo_count - 4'd1;
        default: fifo_count <= fifo_count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  // NOTE: storage has no reset; clearing the pointers and count on reset
  // already discards every entry, and a resettable array costs a mux per bit.
  always_ff @(posedge mvmt_clk) begin
    if (push_ok) mem[wr_ptr] <= {bram_addr_player, bram_din_player};
  end

  always_ff @(posedge mvmt_clk or posedge reset) begin
    if (reset) begin
      bram_we       <= 1'b0;
      bram_addr     <= 8'd0;
      bram_din      <= 9'd0;
      pickups_total <= 8'd0;
    end else begin
      bram_we <= (state_next == WRITE);
      // Address/data only change on issue, so they hold between strobes.
      if (pop) {bram_addr, bram_din} <= mem[rd_ptr];
      if ((state == WRITE) && (pickups_total != 8'hFF)) begin
        pickups_total <= pickups_total + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_pickup_write_queue.sv
// -----------------------------------------------------------------------------
// tb_pickup_write_queue
//
// Self-checking bench for pickup_write_queue (DEPTH=4). A table of per-cycle
// vectors covers single pulses, held requests, enable gating, overflow and the
// 3-cycle commit spacing; hand-written sequences cover the busy stall, reset
// during WRITE, push+pop on a full queue and the PICKUP_DEDUP_EN option.
// -----------------------------------------------------------------------------
module tb_pickup_write_queue;

  logic       mvmt_clk;
  logic       reset;
  logic       en;
  logic       we_player;
  logic [7:0] bram_addr_player;
  logic [8:0] bram_din_player;
  logic       port_busy;
  logic       bram_we;
  logic [7:0] bram_addr;
  logic [8:0] bram_din;
  logic [3:0] fifo_count;
  logic       overflow;
  logic [7:0] pickups_total;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];

`ifdef PICKUP_DEDUP_EN
  localparam int DEDUP_WRITES = 1;
`else
  localparam int DEDUP_WRITES = 2;
`endif

  pickup_write_queue #(.DEPTH(4)) dut (
    .mvmt_clk         (mvmt_clk),
    .reset            (reset),
    .en               (en),
    .we_player        (we_player),
    .bram_addr_player (bram_addr_player),
    .bram_din_player  (bram_din_player),
    .port_busy        (port_busy),
    .bram_we          (bram_we),
    .bram_addr        (bram_addr),
    .bram_din         (bram_din),
    .fifo_count       (fifo_count),
    .overflow         (overflow),
    .pickups_total    (pickups_total)
  );

  initial mvmt_clk = 1'b0;
  always #5 mvmt_clk = ~mvmt_clk;

  typedef struct {
    logic       en;
    logic       we;
    logic [7:0] addr;
    logic [8:0] din;
    logic       busy;
    logic       e_we;
    logic [7:0] e_addr;
    logic [8:0] e_din;
    logic [3:0] e_cnt;
    logic       e_ovf;
    logic [7:0] e_tot;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic i_en, input logic i_we,
                              input logic [7:0] i_addr, input logic [8:0] i_din,
                              input logic i_busy, input logic x_we,
                              input logic [7:0] x_addr, input logic [8:0] x_din,
                              input logic [3:0] x_cnt, input logic x_ovf,
                              input logic [7:0] x_tot);
    vec_t v;
    v.en = i_en;  v.we = i_we;  v.addr = i_addr;  v.din = i_din;  v.busy = i_busy;
    v.e_we = x_we;  v.e_addr = x_addr;  v.e_din = x_din;
    v.e_cnt = x_cnt;  v.e_ovf = x_ovf;  v.e_tot = x_tot;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge mvmt_clk);
    #1;
  endtask

  task automatic drive(input logic i_en, input logic i_we, input logic [7:0] i_addr,
                       input logic [8:0] i_din, input logic i_busy);
    en               = i_en;
    we_player        = i_we;
    bram_addr_player = i_addr;
    bram_din_player  = i_din;
    port_busy        = i_busy;
  endtask

  // Idle inputs for a bounded number of cycles; commits are matched in order
  // against exp_q and counted.
  task automatic drain(input int cycles, input int exp_writes, input string tag);
    int writes;
    writes = 0;
    drive(1'b1, 1'b0, 8'h00, 9'h000, 1'b0);
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (bram_we === 1'b1) begin
        writes++;
        if (exp_q.size() != 0) check({tag, " commit addr"}, 32'(bram_addr), 32'(exp_q.pop_front()));
      end
    end
    check({tag, " commit count"}, 32'(writes), 32'(exp_writes));
    check({tag, " drained count"}, 32'(fifo_count), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 1'b0, 8'h00, 9'h000, 1'b0);

    // Vectors: inputs for one edge, outputs expected just after that edge.
    //            en  we  addr   din    busy we  addr   din    cnt ovf tot
    vq.push_back(mk(1, 0, 8'h00, 9'h000, 0, 0, 8'h00, 9'h000, 0, 0, 8'd0)); // 0
    vq.push_back(mk(1, 1, 8'h35, 9'h001, 0, 0, 8'h00, 9'h000, 1, 0, 8'd0)); // 1 single pulse push
    vq.push_back(mk(1, 0, 8'h00, 9'h000, 0, 1, 8'h35, 9'h001, 0, 0, 8'd0)); // 2 issue
    vq.push_back(mk(1, 0, 8'h00, 9'h000, 0, 0, 8'h35, 9'h001, 0, 0, 8'd1)); // 3 GAP
    vq.push_back(mk(1, 0, 8'h00, 9'h000, 0, 0, 8'h35, 9'h001, 0, 0, 8'd1)); // 4
    vq.push_back(mk(1, 1, 8'h10, 9'h0AB, 0, 0, 8'h35, 9'h001, 1, 0, 8'd1)); // 5 held request
    vq.push_back(mk(1, 1, 8'h10, 9'h0AB, 0, 1, 8'h10, 9'h0AB, 0, 0, 8'd1)); // 6
    vq.push_back(mk(1, 1, 8'h10, 9'h0AB, 0, 0, 8'h10, 9'h0AB, 0, 0, 8'd2)); // 7
    vq.push_back(mk(1, 1, 8'h10, 9'h0AB, 0, 0, 8'h10, 9'h0AB, 0, 0, 8'd2)); // 8
    vq.push_back(mk(1, 1, 8'h10, 9'h0AB, 0, 0, 8'h10, 9'h0AB, 0, 0, 8'd2)); // 9
    vq.push_back(mk(1, 1, 8'h10, 9'h0AB, 0, 0, 8'h10, 9'h0AB, 0, 0, 8'd2)); // 10
    vq.push_back(mk(1, 0, 8'h00, 9'h000, 0, 0, 8'h10, 9'h0AB, 0, 0, 8'd2)); // 11
    vq.push_back(mk(0, 1, 8'h77, 9'h1FF, 0, 0, 8'h10, 9'h0AB, 0, 0, 8'd2)); // 12 en=0 blocks push
    vq.push_back(mk(1, 1, 8'h77, 9'h1FF, 0, 0, 8'h10, 9'h0AB, 0, 0, 8'd2)); // 13 edge already seen
    vq.push_back(mk(1, 0, 8'h00, 9'h000, 0, 0, 8'h10, 9'h0AB, 0, 0, 8'd2)); // 14
    vq.push_back(mk(1, 1, 8'h40, 9'h100, 0, 0, 8'h10, 9'h0AB, 1, 0, 8'd2)); // 15
    vq.push_back(mk(0, 0, 8'h00, 9'h000, 0, 0, 8'h10, 9'h0AB, 1, 0, 8'd2)); // 16 en=0 blocks issue
    vq.push_back(mk(1, 0, 8'h00, 9'h000, 0, 1, 8'h40, 9'h100, 0, 0, 8'd2)); // 17
    vq.push_back(mk(1, 0, 8'h00, 9'h000, 0, 0, 8'h40, 9'h100, 0, 0, 8'd3)); // 18
    vq.push_back(mk(1, 0, 8'h00, 9'h000, 0, 0, 8'h40, 9'h100, 0, 0, 8'd3)); // 19
    vq.push_back(mk(1, 1, 8'h41, 9'h002, 0, 0, 8'h40, 9'h100, 1, 0, 8'd3)); // 20
    vq.push_back(mk(1, 0, 8'h00, 9'h000, 0, 1, 8'h41, 9'h002, 0, 0, 8'd3)); // 21 WRITE
    vq.push_back(mk(0, 0, 8'h00, 9'h000, 0, 0, 8'h41, 9'h002, 0, 0, 8'd4)); // 22 en=0, WRITE completes
    vq.push_back(mk(0, 0, 8'h00, 9'h000, 0, 0, 8'h41, 9'h002, 0, 0, 8'd4)); // 23
    vq.push_back(mk(1, 1, 8'h01, 9'h001, 1, 0, 8'h41, 9'h002, 1, 0, 8'd4)); // 24 overflow fill
    vq.push_back(mk(1, 0, 8'h00, 9'h000, 1, 0, 8'h41, 9'h002, 1, 0, 8'd4)); // 25
    vq.push_back(mk(1, 1, 8'h02, 9'h002, 1, 0, 8'h41, 9'h002, 2, 0, 8'd4)); // 26
    vq.push_back(mk(1, 0, 8'h00, 9'h000, 1, 0, 8'h41, 9'h002, 2, 0, 8'd4)); // 27
    vq.push_back(mk(1, 1, 8'h03, 9'h003, 1, 0, 8'h41, 9'h002, 3, 0, 8'd4)); // 28
    vq.push_back(mk(1, 0, 8'h00, 9'h000, 1, 0, 8'h41, 9'h002, 3, 0, 8'd4)); // 29
    vq.push_back(mk(1, 1, 8'h04, 9'h004, 1, 0, 8'h41, 9'h002, 4, 0, 8'd4)); // 30
    vq.push_back(mk(1, 0, 8'h00, 9'h000, 1, 0, 8'h41, 9'h002, 4, 0, 8'd4)); // 31
    vq.push_back(mk(1, 1, 8'h05, 9'h005, 1, 0, 8'h41, 9'h002, 4, 1, 8'd4)); // 32 dropped
    vq.push_back(mk(1, 0, 8'h00, 9'h000, 1, 0, 8'h41, 9'h002, 4, 1, 8'd4)); // 33
    vq.push_back(mk(1, 0, 8'h00, 9'h000, 0, 1, 8'h01, 9'h001, 3, 1, 8'd4)); // 34 release busy
    vq.push_back(mk(1, 0, 8'h00, 9'h000, 0, 0, 8'h01, 9'h001, 3, 1, 8'd5)); // 35
    vq.push_back(mk(1, 0, 8'h00, 9'h000, 0, 0, 8'h01, 9'h001, 3, 1, 8'd5)); // 36
    vq.push_back(mk(1, 0, 8'h00, 9'h000, 0, 1, 8'h02, 9'h002, 2, 1, 8'd5)); // 37
    vq.push_back(mk(1, 0, 8'h00, 9'h000, 0, 0, 8'h02, 9'h002, 2, 1, 8'd6)); // 38
    vq.push_back(mk(1, 0, 8'h00, 9'h000, 0, 0, 8'h02, 9'h002, 2, 1, 8'd6)); // 39
    vq.push_back(mk(1, 0, 8'h00, 9'h000, 0, 1, 8'h03, 9'h003, 1, 1, 8'd6)); // 40
    vq.push_back(mk(1, 0, 8'h00, 9'h000, 0, 0, 8'h03, 9'h003, 1, 1, 8'd7)); // 41
    vq.push_back(mk(1, 0, 8'h00, 9'h000, 0, 0, 8'h03, 9'h003, 1, 1, 8'd7)); // 42
    vq.push_back(mk(1, 0, 8'h00, 9'h000, 0, 1, 8'h04, 9'h004, 0, 1, 8'd7)); // 43
    vq.push_back(mk(1, 0, 8'h00, 9'h000, 0, 0, 8'h04, 9'h004, 0, 1, 8'd8)); // 44
    vq.push_back(mk(1, 0, 8'h00, 9'h000, 0, 0, 8'h04, 9'h004, 0, 1, 8'd8)); // 45

    // Reset state.
    #12;
    check("reset bram_we",       32'(bram_we),       32'd0);
    check("reset bram_addr",     32'(bram_addr),     32'd0);
    check("reset bram_din",      32'(bram_din),      32'd0);
    check("reset fifo_count",    32'(fifo_count),    32'd0);
    check("reset overflow",      32'(overflow),      32'd0);
    check("reset pickups_total", 32'(pickups_total), 32'd0);
    reset = 1'b0;

    // Table-driven section.
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].en, vq[i].we, vq[i].addr, vq[i].din, vq[i].busy);
      tick();
      check($sformatf("vec%0d bram_we", i),    32'(bram_we),       32'(vq[i].e_we));
      check($sformatf("vec%0d bram_addr", i),  32'(bram_addr),     32'(vq[i].e_addr));
      check($sformatf("vec%0d bram_din", i),   32'(bram_din),      32'(vq[i].e_din));
      check($sformatf("vec%0d fifo_count", i), 32'(fifo_count),    32'(vq[i].e_cnt));
      check($sformatf("vec%0d overflow", i),   32'(overflow),      32'(vq[i].e_ovf));
      check($sformatf("vec%0d total", i),      32'(pickups_total), 32'(vq[i].e_tot));
    end

    // Busy stall: one entry waits 10 cycles, issues on the first free edge.
    drive(1'b1, 1'b1, 8'h5A, 9'h0F0, 1'b1);
    tick();
    check("stall queued", 32'(fifo_count), 32'd1);
    drive(1'b1, 1'b0, 8'h00, 9'h000, 1'b1);
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("stall c%0d bram_we", c), 32'(bram_we), 32'd0);
    end
    port_busy = 1'b0;
    tick();
    check("stall issue bram_we",   32'(bram_we),   32'd1);
    check("stall issue bram_addr", 32'(bram_addr), 32'h5A);
    check("stall issue bram_din",  32'(bram_din),  32'h0F0);
    tick();
    tick();
    check("stall total", 32'(pickups_total), 32'd9);

    // Reset during WRITE with two entries still queued.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 8'(8'h71 + k), 9'(k), 1'b1);
      tick();
      drive(1'b1, 1'b0, 8'h00, 9'h000, 1'b1);
      tick();
    end
    port_busy = 1'b0;
    tick();
    check("rst pre bram_we",    32'(bram_we),    32'd1);
    check("rst pre fifo_count", 32'(fifo_count), 32'd2);
    reset = 1'b1;
    #1;
    check("rst async bram_we",    32'(bram_we),       32'd0);
    check("rst async fifo_count", 32'(fifo_count),    32'd0);
    check("rst async total",      32'(pickups_total), 32'd0);
    check("rst async overflow",   32'(overflow),      32'd0);
    #1;
    reset = 1'b0;
    exp_q.delete();
    drain(10, 0, "post-reset");

    // Full queue with a same-cycle pop: push accepted, count stays at 4.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 8'(8'h61 + k), 9'(k), 1'b1);
      tick();
      drive(1'b1, 1'b0, 8'h00, 9'h000, 1'b1);
      tick();
    end
    check("full count", 32'(fifo_count), 32'd4);
    drive(1'b1, 1'b1, 8'h65, 9'h004, 1'b0);
    tick();
    check("full+pop bram_we",    32'(bram_we),    32'd1);
    check("full+pop bram_addr",  32'(bram_addr),  32'h61);
    check("full+pop fifo_count", 32'(fifo_count), 32'd4);
    check("full+pop overflow",   32'(overflow),   32'd0);
    exp_q.delete();
    exp_q.push_back(8'h62);
    exp_q.push_back(8'h63);
    exp_q.push_back(8'h64);
    exp_q.push_back(8'h65);
    drain(20, 4, "full+pop");
    check("full+pop total", 32'(pickups_total), 32'd5);

    // Two pushes to the same address with one idle cycle between them.
    drive(1'b1, 1'b1, 8'h22, 9'h000, 1'b0);
    tick();
    drive(1'b1, 1'b0, 8'h00, 9'h000, 1'b0);
    tick();
    check("dedup first bram_we",   32'(bram_we),   32'd1);
    check("dedup first bram_addr", 32'(bram_addr), 32'h22);
    drive(1'b1, 1'b1, 8'h22, 9'h000, 1'b0);
    tick();
    drive(1'b1, 1'b0, 8'h00, 9'h000, 1'b0);
    tick();
    exp_q.delete();
    if (DEDUP_WRITES > 1) exp_q.push_back(8'h22);
    drain(15, DEDUP_WRITES - 1, "dedup");
    check("dedup total",    32'(pickups_total), 32'(5 + DEDUP_WRITES));
    check("dedup overflow", 32'(overflow),      32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pickup_write_queue.md
PICKUP_WRITE_QUEUE -- requirements
Module: pickup_write_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of queue entries (power of 2, 2..8).
REQ-002 mvmt_clk  input  1  movement clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 en  input  1  game-active enable; gates new pushes and new issues.
REQ-005 we_player  input  1  pickup write request level from the player movement stage.
REQ-006 bram_addr_player  input  8  maze cell address (row*16+col) to rewrite.
REQ-007 bram_din_player  input  9  replacement cell word (wall bit kept, collectible bits cleared).
REQ-008 port_busy  input  1  another writer owns the maze BRAM write port this cycle.
REQ-009 bram_we  output  1  maze BRAM write strobe, registered.
REQ-010 bram_addr  output  8  maze BRAM write address, registered.
REQ-011 bram_din  output  9  maze BRAM write data, registered.
REQ-012 fifo_count  output  4  entries currently queued, 0..DEPTH.
REQ-013 overflow  output  1  sticky flag: a push was dropped because the queue was full.
REQ-014 pickups_total  output  8  count of committed writes, saturating at 255.

Function
REQ-015 Push: occurs on a cycle where en=1, we_player=1 and we_player was 0 on the previous edge (registered rising-edge detect); {addr,din} is captured from that same cycle.
REQ-016 A held-high we_player SHALL produce exactly one push.
REQ-017 Queue: FIFO order, DEPTH entries of 17 bits, wrap-around read/write pointers.
REQ-018 Full (fifo_count=DEPTH) with no same-cycle pop: push dropped, overflow<=1; overflow stays 1 until reset.
REQ-019 Full with a same-cycle pop: push accepted, fifo_count stays DEPTH, overflow unchanged.
REQ-020 Push on empty queue: entry visible for issue on the next edge (1-cycle minimum push-to-strobe latency is 2 edges).
REQ-021 FSM states: IDLE, WRITE, GAP.
REQ-022 IDLE -> WRITE: when en=1, fifo_count>0 and port_busy=0; on that edge bram_addr/bram_din <= head entry, bram_we<=1, head popped.
REQ-023 WRITE -> GAP unconditionally: bram_we<=0, pickups_total increments (saturates at 255).
REQ-024 GAP -> IDLE unconditionally; bram_we stays 0 (one recovery cycle between writes).
REQ-025 bram_we SHALL be high for exactly one cycle per committed entry; the maximum commit rate is one write per 3 cycles.
REQ-026 bram_addr/bram_din hold their last values while bram_we=0.
REQ-027 port_busy high in IDLE: no issue and the queue is held; port_busy is ignored in WRITE and GAP.
REQ-028 en=0: pushes and new issues blocked; an in-progress WRITE/GAP completes; the rising-edge detect register still tracks we_player.
REQ-029 Simultaneous push and pop: both are performed and fifo_count is unchanged.

Reset
REQ-030 On reset: FSM=IDLE, pointers=0, fifo_count=0, bram_we=0, bram_addr=0, bram_din=0, overflow=0, pickups_total=0, edge-detect register=0.
REQ-031 Reset mid-WRITE: bram_we drops immediately (asynchronously) and all queued entries are discarded.

Configuration
REQ-032 Macro PICKUP_DEDUP_EN defined: a push whose address equals the last accepted push address (valid since reset) is discarded silently, with no overflow and no count change.
REQ-033 PICKUP_DEDUP_EN undefined: every qualifying push is accepted as per REQ-015..REQ-019; no last-address register is built.

Verification
REQ-034 Single pulse: we_player 1 cycle, addr=0x35, din=0x001, port_busy=0 -> one bram_we pulse with bram_addr=0x35, bram_din=0x001; pickups_total=1; fifo_count returns to 0.
REQ-035 Held request: we_player high 6 cycles, addr=0x10 -> exactly one commit; pickups_total=1.
REQ-036 Overflow, DEPTH=4: 5 pushes (addrs 1..5) with port_busy=1 -> fifo_count=4, overflow=1; release port_busy -> commits 1,2,3,4 in order, each spaced 3 cycles apart.
REQ-037 Busy stall: 1 entry queued, port_busy=1 for 10 cycles -> bram_we stays 0; the write issues on the first edge after port_busy=0.
REQ-038 Reset mid-operation: assert reset during WRITE with 2 entries queued -> bram_we=0 immediately, fifo_count=0, no further writes after release.
REQ-039 PICKUP_DEDUP_EN defined: two pushes to 0x22 separated by one idle cycle -> one commit; without the macro -> two commits.
